snax_mac_job_sequencer: RTL
===========================

SNAX_MAC_JOB_SEQUENCER -- requirements
Module: snax_mac_job_sequencer

Interface
REQ-001 SHALL have parameter DataWidth, default 32, width of the periph data and of each job register.
REQ-002 SHALL have parameter NumJobRegs, default 4, number of job registers written per job (1..16).
REQ-003 SHALL have parameter IdWidth, default 5, width of the periph id.
REQ-004 SHALL have parameter PeriphId, default 0, constant id driven on every periph request.
REQ-005 SHALL have parameter JobRegBase, default 32'h40, periph address of job register 0; register k is at JobRegBase+4k.
REQ-006 SHALL have port clk_i, input, 1, clock; one clock, all state on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port job_valid_i, input, 1, job descriptor valid.
REQ-009 SHALL have port job_ready_o, output, 1, job descriptor accepted.
REQ-010 SHALL have port job_regs_i, input, NumJobRegs*DataWidth, job register values, reg k at bits [k*DataWidth +: DataWidth].
REQ-011 SHALL have port periph_req_o, input/output pair: periph_req_o output 1, periph_gnt_i input 1, the request/grant handshake.
REQ-012 SHALL have ports periph_add_o (out, 32), periph_wen_o (out, 1; 0=write, 1=read), periph_be_o (out, 4), periph_data_o (out, DataWidth), periph_id_o (out, IdWidth).
REQ-013 SHALL have ports periph_r_data_i (in, DataWidth), periph_r_valid_i (in, 1), periph_r_id_i (in, IdWidth).
REQ-014 SHALL have port evt_i, input, 1, engine end-of-job event pulse.
REQ-015 SHALL have ports done_valid_o (out, 1), done_ready_i (in, 1), done_cycles_o (out, 32), the completion report and its cycle count.
REQ-016 SHALL have port busy_o, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACQ_REQ, ACQ_RSP, CFG, TRIG, WAIT, REPORT.
REQ-018 IDLE: job_ready_o=1; on job_valid_i&job_ready_o, SHALL latch job_regs_i into internal registers and go to ACQ_REQ.
REQ-019 ACQ_REQ: SHALL drive a read request, add=32'h04, be=4'hF, wen=1; on periph_gnt_i, go to ACQ_RSP.
REQ-020 ACQ_RSP: on periph_r_valid_i with periph_r_id_i==PeriphId, SHALL check r_data[31]. If 1 (locked), return to ACQ_REQ after a 4-cycle backoff; if 0, go to CFG with index=0. Responses with other ids SHALL be ignored.
REQ-021 CFG: SHALL write latched reg[index] to JobRegBase+4*index with wen=0, be=4'hF. Each grant increments index; the grant at index=NumJobRegs-1 moves to TRIG.
REQ-022 TRIG: SHALL write 32'h0 to add=32'h00; on grant, clear the cycle counter to 0 and go to WAIT.
REQ-023 WAIT: the counter SHALL increment each cycle and saturate at 32'hFFFF_FFFF. On evt_i, go to REPORT with done_cycles_o = counter value in the evt_i cycle.
REQ-024 REPORT: done_valid_o=1 with done_cycles_o stable until done_ready_i; the handshake cycle returns to IDLE.
REQ-025 While periph_req_o=1, add/wen/be/data/id SHALL be held stable until periph_gnt_i; at most one request per grant, no new request in the grant cycle's successor until state update.
REQ-026 periph_id_o SHALL always equal PeriphId; periph_req_o SHALL be 0 in IDLE, ACQ_RSP, WAIT, REPORT and during backoff.
REQ-027 evt_i outside WAIT SHALL be ignored; job_valid_i outside IDLE SHALL not be accepted (job_ready_o=0).
REQ-028 A combinational path from periph_gnt_i to periph_req_o is permitted; there SHALL be no combinational path from job_valid_i to any periph output.

Reset
REQ-029 On rst_ni=0 (any state, asynchronously), SHALL enter IDLE; periph_req_o=0, periph_wen_o=1, add/be/data=0, done_valid_o=0, done_cycles_o=0, busy_o=0, job_ready_o=1 after release, counter=0, index=0.

Verification
REQ-030 Single job, NumJobRegs=4, regs {0x11,0x22,0x33,0x44}, gnt always 1, acquire r_data=0, evt_i 10 cycles after trigger grant -> writes 0x40..0x4C with 0x11..0x44, trigger write to 0x00, done_cycles_o=10.
REQ-031 Acquire returns 0x8000_0000 twice then 0 -> three reads at 0x04, each retry exactly 4 idle cycles after its locked response; then normal CFG.
REQ-032 gnt withheld 3 cycles on CFG index 2 -> add=0x48, data=0x33 held for 4 cycles; no duplicate or skipped writes.
REQ-033 done_ready_i low 5 cycles in REPORT; job_valid_i high throughout -> done held stable, job_ready_o=0 until the REPORT handshake, next job accepted only in IDLE.
REQ-034 rst_ni asserted in WAIT; evt_i pulses in CFG and in the 2nd ACQ_RSP with r_id!=PeriphId -> outputs at reset values immediately; spurious evt_i and foreign-id responses cause no state change.

Source files
------------

// File: rtl/snax_mac_job_sequencer.sv
// Job sequencer for a SNAX MAC accelerator.
// Takes a job descriptor, acquires the engine lock over the periph bus,
// writes the job registers, triggers the engine, times the job until the
// end-of-job event and reports the cycle count on a valid/ready channel.
module snax_mac_job_sequencer #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned NumJobRegs = 4,
    parameter int unsigned IdWidth    = 5,
    parameter int unsigned PeriphId   = 0,
    parameter logic [31:0] JobRegBase = 32'h40
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             job_valid_i,
    output logic                             job_ready_o,
    input  logic [NumJobRegs*DataWidth-1:0]  job_regs_i,
    output logic                             periph_req_o,
    input  logic                             periph_gnt_i,
    output logic [31:0]                      periph_add_o,
    output logic                             periph_wen_o,
    output logic [3:0]                       periph_be_o,
    output logic [DataWidth-1:0]             periph_data_o,
    output logic [IdWidth-1:0]               periph_id_o,
    input  logic [DataWidth-1:0]             periph_r_data_i,
    input  logic                             periph_r_valid_i,
    input  logic [IdWidth-1:0]               periph_r_id_i,
    input  logic                             evt_i,
    output logic                             done_valid_o,
    input  logic                             done_ready_i,
    output logic [31:0]                      done_cycles_o,
    output logic                             busy_o
);

    localparam int unsigned IdxW = (NumJobRegs > 1) ? $clog2(NumJobRegs) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumJobRegs - 1);
    localparam logic [2:0] BackoffCycles = 3'd4;

    typedef enum logic [2:0] {
        IDLE, ACQ_REQ, ACQ_RSP, CFG, TRIG, WAIT, REPORT
    } state_t;

    state_t            state_reg, state_next;
    logic [IdxW-1:0]   index_reg, index_next;
    logic [2:0]        backoff_reg, backoff_next;
    logic [31:0]       cycles_reg, cycles_next;
    logic [31:0]       done_cycles_reg, done_cycles_next;
    logic              latch_en;
    logic [DataWidth-1:0] job_word [NumJobRegs];

    logic        rsp_match;
    logic        lock_bit;
    logic [31:0] cycles_inc;
    logic        unused_rdata;

    assign rsp_match    = periph_r_valid_i && (periph_r_id_i == IdWidth'(PeriphId));
    assign lock_bit     = periph_r_data_i[31];
    assign unused_rdata = ^periph_r_data_i;
    // Counter saturates instead of wrapping so a hung engine reports all-ones.
    assign cycles_inc   = (&cycles_reg) ? cycles_reg : cycles_reg + 32'd1;

    // Per-register descriptor capture when a job is accepted.
    for (genvar gi = 0; gi < NumJobRegs; gi++) begin : g_job_reg
        logic [DataWidth-1:0] value_reg;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                value_reg <= '0;
            end else if (latch_en) begin
                value_reg <= job_regs_i[gi*DataWidth +: DataWidth];
            end
        end
        assign job_word[gi] = value_reg;
    end

    // State, index, backoff, cycle counter and report registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= IDLE;
            index_reg       <= '0;
            backoff_reg     <= '0;
            cycles_reg      <= '0;
            done_cycles_reg <= '0;
        end else begin
            state_reg       <= state_next;
            index_reg       <= index_next;
            backoff_reg     <= backoff_next;
            cycles_reg      <= cycles_next;
            done_cycles_reg <= done_cycles_next;
        end
    end

    // Next-state and output decode; bus fields depend only on registered
    // state so they stay stable while a request waits for its grant.
    always_comb begin
        state_next       = state_reg;
        index_next       = index_reg;
        backoff_next     = backoff_reg;
        cycles_next      = cycles_reg;
        done_cycles_next = done_cycles_reg;
        latch_en         = 1'b0;
        job_ready_o      = 1'b0;
        periph_req_o     = 1'b0;
        periph_add_o     = '0;
        periph_wen_o     = 1'b1;
        periph_be_o      = '0;
        periph_data_o    = '0;
        done_valid_o     = 1'b0;
        case (state_reg)
            IDLE: begin
                job_ready_o = 1'b1;
                if (job_valid_i) begin
                    latch_en     = 1'b1;
                    backoff_next = '0;
                    state_next   = ACQ_REQ;
                end
            end
            ACQ_REQ: begin
                if (backoff_reg != '0) begin
                    // Lock was busy: stay off the bus for the backoff window.
                    backoff_next = backoff_reg - 3'd1;
                end else begin
                    periph_req_o = 1'b1;
                    periph_add_o = 32'h04;
                    periph_be_o  = 4'hF;
                    periph_wen_o = 1'b1;
                    if (periph_gnt_i) begin
                        state_next = ACQ_RSP;
                    end
                end
            end
            ACQ_RSP: begin
                if (rsp_match) begin
                    if (lock_bit) begin
                        backoff_next = BackoffCycles;
                        state_next   = ACQ_REQ;
                    end else begin
                        index_next = '0;
                        state_next = CFG;
                    end
                end
            end
            CFG: begin
                periph_req_o  = 1'b1;
                periph_wen_o  = 1'b0;
                periph_be_o   = 4'hF;
                periph_add_o  = JobRegBase + {{(30-IdxW){1'b0}}, index_reg, 2'b00};
                periph_data_o = job_word[index_reg];
                if (periph_gnt_i) begin
                    if (index_reg == LastIdx) begin
                        index_next = '0;
                        state_next = TRIG;
                    end else begin
                        index_next = index_reg + 1'b1;
                    end
                end
            end
            TRIG: begin
                periph_req_o = 1'b1;
                periph_wen_o = 1'b0;
                periph_be_o  = 4'hF;
                periph_add_o = 32'h00;
                if (periph_gnt_i) begin
                    cycles_next = '0;
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                // Reported count includes the cycle in which the event arrives.
                cycles_next = cycles_inc;
                if (evt_i) begin
                    done_cycles_next = cycles_inc;
                    state_next       = REPORT;
                end
            end
            REPORT: begin
                done_valid_o = 1'b1;
                if (done_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign periph_id_o   = IdWidth'(PeriphId);
    assign done_cycles_o = done_cycles_reg;
    assign busy_o        = (state_reg != IDLE);

endmodule
